stopwatch_counter: RTL and testbench

STOPWATCH_COUNTER -- requirements
Module: stopwatch_counter

---
 rtl/stopwatch_pkg.sv | 17 +
 rtl/stopwatch_counter_if.sv | 25 ++
 rtl/bcd60_counter.sv | 33 +++
 rtl/stopwatch_counter.sv | 90 +++++++++
 tb/tb_stopwatch_counter.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and limits for the MM:SS stopwatch.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PAUSE = 2'd1,
    ST_ADJ   = 2'd2
  } sw_state_e;

  localparam logic [1:0] ADJ_NONE = 2'b00;
  localparam logic [1:0] ADJ_SEC  = 2'b01;
  localparam logic [1:0] ADJ_MIN  = 2'b10;

  localparam logic [3:0] MAX_TENS = 4'd5;
  localparam logic [3:0] MAX_ONES = 4'd9;

endpackage

// File: rtl/stopwatch_counter_if.sv
// Control pulses in, BCD digits and status out.
interface stopwatch_counter_if;
  logic       tick_1hz;
  logic       tick_2hz;
  logic       pause_p;
  logic       clr_p;
  logic       adj;
  logic       sel;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       running;
  logic [1:0] adj_field;

  modport master (
    output tick_1hz, tick_2hz, pause_p, clr_p, adj, sel,
    input  min_tens, min_ones, sec_tens, sec_ones, running, adj_field
  );

  modport slave (
    input  tick_1hz, tick_2hz, pause_p, clr_p, adj, sel,
    output min_tens, min_ones, sec_tens, sec_ones, running, adj_field
  );
endinterface

// File: rtl/bcd60_counter.sv
// Two-digit BCD counter 00..59; clr wins over inc, carry_out flags the 59->00 step.
module bcd60_counter
  import stopwatch_pkg::*;
(
  input  logic       clk_master,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       clr,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       carry_out
);

  assign carry_out = inc && (tens == MAX_TENS) && (ones == MAX_ONES);

  always_ff @(posedge clk_master or negedge rst_n) begin
    if (!rst_n) begin
      tens <= 4'd0;
      ones <= 4'd0;
    end else if (clr) begin
      tens <= 4'd0;
      ones <= 4'd0;
    end else if (inc) begin
      if (ones == MAX_ONES) begin
        ones <= 4'd0;
        tens <= (tens == MAX_TENS) ? 4'd0 : tens + 4'd1;
      end else begin
        ones <= ones + 4'd1;
      end
    end
  end

endmodule

// File: rtl/stopwatch_counter.sv
// MM:SS stopwatch with run / pause / adjust modes driven by divider ticks.
module stopwatch_counter
  import stopwatch_pkg::*;
(
  input  logic                clk_master,
  input  logic                rst_n,
  stopwatch_counter_if.slave  bus
);

  // Assert asynchronously, release two edges after rst_n rises.
  logic [1:0] rst_sync;
  logic       rst_int_n;

  always_ff @(posedge clk_master or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_int_n = rst_sync[1];

  sw_state_e state;
  logic      in_run, in_adj;
  logic      sec_inc, min_inc, sec_carry, min_carry;

  assign in_run = (state == ST_RUN);
  assign in_adj = (state == ST_ADJ);

  // Carry only rolls into minutes while running; adjust touches one field.
  assign sec_inc = (in_run && bus.tick_1hz) || (in_adj && bus.tick_2hz && !bus.sel);
  assign min_inc = (in_run && bus.tick_1hz && sec_carry) ||
                   (in_adj && bus.tick_2hz && bus.sel);

  bcd60_counter u_sec (
    .clk_master (clk_master),
    .rst_n      (rst_int_n),
    .inc        (sec_inc),
    .clr        (bus.clr_p),
    .tens       (bus.sec_tens),
    .ones       (bus.sec_ones),
    .carry_out  (sec_carry)
  );

  bcd60_counter u_min (
    .clk_master (clk_master),
    .rst_n      (rst_int_n),
    .inc        (min_inc),
    .clr        (bus.clr_p),
    .tens       (bus.min_tens),
    .ones       (bus.min_ones),
    .carry_out  (min_carry)
  );

  always_ff @(posedge clk_master or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state         <= ST_RUN;
      bus.running   <= 1'b1;
      bus.adj_field <= ADJ_NONE;
    end else begin
      bus.adj_field <= ADJ_NONE;
      if (bus.adj) begin
        state         <= ST_ADJ;
        bus.running   <= 1'b0;
        bus.adj_field <= bus.sel ? ADJ_MIN : ADJ_SEC;
      end else begin
        case (state)
          ST_RUN: if (bus.pause_p) begin
            state       <= ST_PAUSE;
            bus.running <= 1'b0;
          end
          ST_PAUSE: if (bus.pause_p) begin
            state       <= ST_RUN;
            bus.running <= 1'b1;
          end
          ST_ADJ: begin
            state       <= ST_PAUSE;
            bus.running <= 1'b0;
          end
          default: begin
            state       <= ST_RUN;
            bus.running <= 1'b1;
          end
        endcase
      end
    end
  end

  logic unused_carry;
  assign unused_carry = min_carry;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench: time-in-seconds model checked every cycle plus literal checkpoints.
module tb_stopwatch_counter;

  logic clk_master = 1'b0;
  logic rst_n      = 1'b0;
  always #5 clk_master = ~clk_master;

  stopwatch_counter_if bus ();

  stopwatch_counter dut (
    .clk_master (clk_master),
    .rst_n      (rst_n),
    .bus        (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Model: minutes/seconds as integers, mode 0=run 1=pause 2=adjust.
  int m_mm, m_ss, m_mode, m_af, m_rel;

  always @(posedge clk_master or negedge rst_n) begin
    if (!rst_n) begin
      m_mm = 0; m_ss = 0; m_mode = 0; m_af = 0; m_rel = 0;
    end else if (m_rel < 2) begin
      m_rel++;
    end else begin
      int t;
      if (bus.clr_p) begin
        m_mm = 0; m_ss = 0;
      end else if (m_mode == 0 && bus.tick_1hz) begin
        t = (m_mm * 60 + m_ss + 1) % 3600;
        m_mm = t / 60; m_ss = t % 60;
      end else if (m_mode == 2 && bus.tick_2hz) begin
        if (bus.sel) m_mm = (m_mm + 1) % 60;
        else         m_ss = (m_ss + 1) % 60;
      end
      if (bus.adj)              m_mode = 2;
      else if (m_mode == 2)     m_mode = 1;
      else if (bus.pause_p)     m_mode = (m_mode == 0) ? 1 : 0;
      m_af = (m_mode == 2) ? (bus.sel ? 2 : 1) : 0;
    end
  end

  always @(posedge clk_master) begin
    #2;
    if (chk_en) begin
      logic [17:0] exp_v, act_v;
      exp_v = {4'(m_mm / 10), 4'(m_mm % 10), 4'(m_ss / 10), 4'(m_ss % 10),
               (m_mode == 0), 2'(m_af)};
      act_v = {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones,
               bus.running, bus.adj_field};
      n_checks++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL model_cycle t=%0t got=%h want=%h", $time, act_v, exp_v);
      end
    end
  end

  task automatic chk(input string name, input int mm, input int ss,
                     input logic run, input logic [1:0] af);
    logic [17:0] exp_v, act_v;
    exp_v = {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), run, af};
    act_v = {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones,
             bus.running, bus.adj_field};
    n_checks++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h", name, act_v, exp_v);
    end
  endtask

  // kind: 1=t1 2=t2 3=pause 4=clr 5=t1+t2 6=clr+t1
  task automatic pulse(input int kind, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_master);
      case (kind)
        1: bus.tick_1hz = 1'b1;
        2: bus.tick_2hz = 1'b1;
        3: bus.pause_p  = 1'b1;
        4: bus.clr_p    = 1'b1;
        5: begin bus.tick_1hz = 1'b1; bus.tick_2hz = 1'b1; end
        6: begin bus.clr_p = 1'b1; bus.tick_1hz = 1'b1; end
        default: ;
      endcase
      @(negedge clk_master);
      bus.tick_1hz = 1'b0; bus.tick_2hz = 1'b0;
      bus.pause_p  = 1'b0; bus.clr_p    = 1'b0;
    end
  endtask

  task automatic set_adj(input logic a, input logic s);
    @(negedge clk_master);
    bus.adj = a; bus.sel = s;
    @(negedge clk_master);
  endtask

  initial begin
    bus.tick_1hz = 1'b0; bus.tick_2hz = 1'b0; bus.pause_p = 1'b0;
    bus.clr_p    = 1'b0; bus.adj      = 1'b0; bus.sel     = 1'b0;
    repeat (3) @(negedge clk_master);
    chk("reset_state", 0, 0, 1'b1, 2'b00);
    rst_n = 1'b1;
    repeat (4) @(negedge clk_master);
    chk_en = 1'b1;

    pulse(1, 65);
    chk("run_65_ticks", 1, 5, 1'b1, 2'b00);

    // Preload 59:58 through adjust, then back to run.
    set_adj(1'b1, 1'b1);
    pulse(2, 58);
    set_adj(1'b1, 1'b0);
    pulse(2, 53);
    chk("preload_5958", 59, 58, 1'b0, 2'b01);
    set_adj(1'b0, 1'b0);
    pulse(3, 1);
    chk("resume_run", 59, 58, 1'b1, 2'b00);
    pulse(1, 2);
    chk("wrap_5959", 0, 0, 1'b1, 2'b00);

    pulse(1, 10);
    pulse(3, 1);
    pulse(1, 5);
    chk("pause_holds", 0, 10, 1'b0, 2'b00);
    pulse(3, 1);
    pulse(1, 1);
    chk("unpause_counts", 0, 11, 1'b1, 2'b00);

    pulse(1, 47);
    set_adj(1'b1, 1'b0);
    pulse(2, 3);
    chk("adj_sec_wrap", 0, 1, 1'b0, 2'b01);
    set_adj(1'b1, 1'b1);
    pulse(2, 2);
    chk("adj_min", 2, 1, 1'b0, 2'b10);

    pulse(2, 10);
    set_adj(1'b1, 1'b0);
    pulse(2, 33);
    set_adj(1'b0, 1'b0);
    pulse(3, 1);
    chk("at_1234", 12, 34, 1'b1, 2'b00);
    pulse(6, 1);
    chk("clr_beats_tick", 0, 0, 1'b1, 2'b00);
    pulse(2, 1);
    pulse(5, 1);
    chk("run_ignores_t2", 0, 1, 1'b1, 2'b00);

    set_adj(1'b1, 1'b1);
    pulse(2, 7);
    pulse(1, 1);
    set_adj(1'b1, 1'b0);
    pulse(5, 1);
    pulse(2, 5);
    chk("adj_0707", 7, 7, 1'b0, 2'b01);

    // Short asynchronous reset pulse between edges.
    @(posedge clk_master);
    #3 rst_n = 1'b0;
    #1 chk("async_reset", 0, 0, 1'b1, 2'b00);
    #2 rst_n = 1'b1;
    repeat (4) @(negedge clk_master);
    chk("post_reset_adj", 0, 0, 1'b0, 2'b01);
    set_adj(1'b0, 1'b0);
    pulse(3, 1);
    pulse(1, 3);
    chk("recover_count", 0, 3, 1'b1, 2'b00);

    repeat (2) @(negedge clk_master);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
